mul_accum: RTL

//   Downstream stage of the 4x4 combinational multiplier (imul).

---
 rtl/mul_accum.sv | 103 ++++++++++
 1 files changed

// File: rtl/mul_accum.sv
// Accumulates a fixed batch of NPROD products from the imul multiplier and
// presents the registered batch sum through a valid/ready handshake.
module mul_accum #(
  parameter int PROD_WIDTH = 8,
  parameter int ACC_WIDTH  = 10,
  parameter int NPROD      = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  wClear,
  input  logic [PROD_WIDTH-1:0] wProduct,
  input  logic                  wProductValid,
  output logic                  oProductReady,
  output logic [ACC_WIDTH-1:0]  oSum,
  output logic                  oSumValid,
  input  logic                  wSumReady,
  output logic                  oOverflow,
  output logic [7:0]            oCount
);

  localparam logic       ST_ACCUM = 1'b0;
  localparam logic       ST_HOLD  = 1'b1;
  localparam logic [7:0] NPROD_C  = 8'(NPROD);

  logic                 state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [7:0]           cnt_q, cnt_d;

  logic                 accept_s;
  logic                 consume_s;
  logic                 last_s;
  logic [7:0]           cnt_inc_s;
  logic [ACC_WIDTH:0]   prod_ext_s;
  logic [ACC_WIDTH:0]   sum_ext_s;

  always_comb begin
    accept_s   = wProductValid & (state_q == ST_ACCUM);
    consume_s  = wSumReady & (state_q == ST_HOLD);
    cnt_inc_s  = cnt_q + 8'd1;
    last_s     = accept_s & (cnt_inc_s == NPROD_C);
    prod_ext_s = '0;
    prod_ext_s[PROD_WIDTH-1:0] = wProduct;
    // The extra top bit of the sum is the carry-out that feeds the sticky overflow.
    sum_ext_s  = {1'b0, acc_q} + prod_ext_s;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (wClear) begin
      state_d = ST_ACCUM;
    end else begin
      case (state_q)
        ST_ACCUM: state_d = last_s ? ST_HOLD : ST_ACCUM;
        ST_HOLD:  state_d = consume_s ? ST_ACCUM : ST_HOLD;
        default:  state_d = ST_ACCUM;
      endcase
    end
  end

  // A clear beats any same-cycle accept or consume; consume empties the batch.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (wClear || consume_s) begin
      acc_d = '0;
      ovf_d = 1'b0;
      cnt_d = 8'd0;
    end else if (accept_s) begin
      acc_d = sum_ext_s[ACC_WIDTH-1:0];
      ovf_d = ovf_q | sum_ext_s[ACC_WIDTH];
      cnt_d = cnt_inc_s;
    end else begin
      acc_d = acc_q;
      ovf_d = ovf_q;
      cnt_d = cnt_q;
    end
  end

  always_comb begin
    oProductReady = (state_q == ST_ACCUM);
    oSumValid     = (state_q == ST_HOLD);
    oSum          = acc_q;
    oOverflow     = ovf_q;
    oCount        = cnt_q;
  end

endmodule
